// File: rtl/adc_ltc2308_reader.sv
`default_nettype none
// ============================================================================
// Module   : adc_ltc2308_reader
// Purpose  : Free-running LTC2308 reader alternating left/right channels and
//            presenting the latest coherent pair as {R, L} on adc_value.
//            Define ADC_AVG_EN to output the mean of four results per channel.
// Revision : 1.0 - initial release
// ============================================================================
module adc_ltc2308_reader #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int CH_L        = 0,
    parameter int CH_R        = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic [23:0] adc_value,
    output logic        adc_valid
);

    localparam logic [15:0] c_START_LAST = 16'd1;
    localparam logic [15:0] c_WAIT_LAST  = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] c_DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [4:0]  c_HALF_LAST  = 5'd23;
    localparam logic [2:0]  c_CH_L       = 3'(CH_L);
    localparam logic [2:0]  c_CH_R       = 3'(CH_R);
    localparam logic [5:0]  c_CFG_L      = {1'b1, c_CH_L[0], c_CH_L[2:1], 2'b10};
    localparam logic [5:0]  c_CFG_R      = {1'b1, c_CH_R[0], c_CH_R[2:1], 2'b10};

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic [4:0]  r_half;
    logic        r_in_start;
    logic        r_sck;
    logic        r_sdi;
    logic [11:0] r_shift;
    logic        r_next_ch;
    logic        r_prev_ch;
    logic        r_first;
    logic [23:0] r_value;
    logic        r_valid;
    logic        w_tick;
    logic        w_rise;
    logic        w_fall;
    logic [3:0]  w_period_next;
    logic [5:0]  w_cfg;
    logic        w_cfg_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_START: if (r_cnt == c_START_LAST) w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == c_WAIT_LAST)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_tick && (r_half == c_HALF_LAST)) w_state_next = S_DONE;
            default: w_state_next = S_START;
        endcase
    end

    // Within SHIFT the counter measures one SCK half-period; r_half counts halves.
    assign w_tick        = (r_state == S_SHIFT) && (r_cnt == c_DIV_LAST);
    assign w_rise        = w_tick && !r_half[0];
    assign w_fall        = w_tick &&  r_half[0];
    assign w_period_next = r_half[4:1] + 4'd1;
    assign w_cfg         = r_next_ch ? c_CFG_R : c_CFG_L;
    assign w_cfg_bit     = (w_period_next < 4'd6) ? w_cfg[3'd5 - w_period_next[2:0]] : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_half     <= '0;
            r_in_start <= 1'b1;
            r_sck      <= 1'b0;
            r_sdi      <= 1'b0;
            r_shift    <= '0;
        end else begin
            r_in_start <= (w_state_next == S_START);
            if ((w_state_next != r_state) || w_tick) r_cnt <= '0;
            else                                     r_cnt <= r_cnt + 16'd1;
            if (r_state != S_SHIFT) r_half <= '0;
            else if (w_tick)        r_half <= r_half + 5'd1;
            if (w_tick) r_sck <= ~r_sck;
            if ((r_state == S_WAIT) && (w_state_next == S_SHIFT)) r_sdi <= w_cfg[5];
            else if (w_fall)                                        r_sdi <= w_cfg_bit;
            if (w_rise) r_shift <= {r_shift[10:0], adc_sdo};
        end
    end

`ifdef ADC_AVG_EN
    logic [13:0] r_acc_l;
    logic [13:0] r_acc_r;
    logic [1:0]  r_avg_cnt;
    logic [13:0] w_sum_r;

    assign w_sum_r = r_acc_r + {2'b00, r_shift};
`else
    logic [11:0] r_hold_l;
`endif

    // Data shifted in this pass answers the config sent in the previous pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_ch <= 1'b0;
            r_prev_ch <= 1'b0;
            r_first   <= 1'b1;
            r_value   <= '0;
            r_valid   <= 1'b0;
`ifdef ADC_AVG_EN
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            r_avg_cnt <= '0;
`else
            r_hold_l  <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (r_state == S_DONE) begin
                r_prev_ch <= r_next_ch;
                r_next_ch <= ~r_next_ch;
                if (r_first) begin
                    r_first <= 1'b0;
                end else if (!r_prev_ch) begin
`ifdef ADC_AVG_EN
                    r_acc_l <= r_acc_l + {2'b00, r_shift};
`else
                    r_hold_l <= r_shift;
`endif
                end else begin
`ifdef ADC_AVG_EN
                    if (r_avg_cnt == 2'd3) begin
                        r_value <= {w_sum_r[13:2], r_acc_l[13:2]};
                        r_valid <= 1'b1;
                        r_acc_l <= '0;
                        r_acc_r <= '0;
                    end else begin
                        r_acc_r <= w_sum_r;
                    end
                    r_avg_cnt <= r_avg_cnt + 2'd1;
`else
                    r_value <= {r_shift, r_hold_l};
                    r_valid <= 1'b1;
`endif
                end
            end
        end
    end

    // CONVST must be high from the very first cycle after release yet low in reset.
    assign adc_convst = r_in_start & ~reset;
    assign adc_sck    = r_sck;
    assign adc_sdi    = r_sdi;
    assign adc_value  = r_value;
    assign adc_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_adc_ltc2308_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_ltc2308_reader
// Purpose  : Self-checking bench with a behavioural LTC2308 model and a
//            pair/average scoreboard for adc_ltc2308_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_ltc2308_reader;

    localparam int c_CLK_DIV = 2;
    localparam int c_CONV    = 80;
    localparam int c_CH_L    = 0;
    localparam int c_CH_R    = 1;
    localparam int c_FRAME   = 2 + c_CONV + 24 * c_CLK_DIV + 1;
`ifdef ADC_AVG_EN
    localparam int c_AVG     = 4;
`else
    localparam int c_AVG     = 1;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        sdo   = 1'b0;
    logic        convst;
    logic        sck;
    logic        sdi;
    logic        valid;
    logic [23:0] value;

    always #5 clk = ~clk;

    adc_ltc2308_reader #(
        .CLK_DIV     (c_CLK_DIV),
        .CONV_CYCLES (c_CONV),
        .CH_L        (c_CH_L),
        .CH_R        (c_CH_R)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .adc_convst (convst),
        .adc_sck    (sck),
        .adc_sdi    (sdi),
        .adc_sdo    (sdo),
        .adc_value  (value),
        .adc_valid  (valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] cfg_word(input int ch);
        logic [2:0] c;
        c = 3'(ch);
        return {1'b1, c[0], c[2:1], 2'b10};
    endfunction

    // Code source: 0 fixed pair, 1 random, 2 boundary table, 3 ramp.
    int          mode = 0;
    int          bnd_pos = 0;
    logic [11:0] ramp = 12'h000;
    logic [11:0] bnd [10] = '{12'h000, 12'h001, 12'h7FF, 12'h800, 12'h801,
                              12'hFFE, 12'hFFF, 12'hAAA, 12'h555, 12'h0F0};

    int          cyc, conv_idx, rises, hi_cnt, cfg_bits, out_pos;
    int          n_valid, last_conv, last_valid, avg_n, sum_l, sum_r;
    logic [5:0]  cfg;
    logic [11:0] out_word, code;
    logic [23:0] held;
    logic        prev_convst, prev_sck, is_r;
    logic [23:0] exp_q[$];

    // ADC model and scoreboard, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0; conv_idx = 0; rises = 0; hi_cnt = 0; cfg_bits = 0; out_pos = -1;
                n_valid = 0; last_conv = 0; last_valid = 0; avg_n = 0; sum_l = 0; sum_r = 0;
                cfg = '0; out_word = '0; held = '0; prev_convst = 1'b0; prev_sck = 1'b0;
                sdo = 1'b0;
                exp_q.delete();
            end else begin
                if (valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        held = exp_q.pop_front();
                        chk("value", value, held);
                    end
                    if (n_valid == 0) chk("first_valid_cyc", cyc, (1 + 2 * c_AVG) * c_FRAME);
                    else              chk("valid_period", cyc - last_valid, 2 * c_AVG * c_FRAME);
                    n_valid++;
                    last_valid = cyc;
                end else begin
                    chk("value_hold", value, held);
                end

                if (convst) begin
                    hi_cnt++;
                end else if (prev_convst) begin
                    chk("convst_width", hi_cnt, 2);
                    hi_cnt = 0;
                end

                if (convst && !prev_convst) begin
                    if (conv_idx > 0) begin
                        chk("frame_len", cyc - last_conv, c_FRAME);
                        chk("sck_rises", rises, 12);
                        chk("cfg_bits", cfg_bits, 6);
                        chk("cfg_word", cfg, cfg_word((conv_idx % 2 == 1) ? c_CH_L : c_CH_R));
                    end
                    is_r = (conv_idx % 2 == 0);
                    if (conv_idx == 0) begin
                        code = 12'($urandom);
                    end else begin
                        case (mode)
                            0: code = is_r ? 12'hABC : 12'h123;
                            1: code = 12'($urandom);
                            2: begin
                                code = bnd[bnd_pos];
                                bnd_pos = (bnd_pos + 1) % 10;
                            end
                            default: begin
                                code = ramp;
                                ramp = ramp + 12'h111;
                            end
                        endcase
                        if (!is_r) begin
                            sum_l += int'(code);
                        end else begin
                            sum_r += int'(code);
                            avg_n++;
                            if (avg_n == c_AVG) begin
                                exp_q.push_back({12'(sum_r / c_AVG), 12'(sum_l / c_AVG)});
                                sum_l = 0; sum_r = 0; avg_n = 0;
                            end
                        end
                    end
                    out_word  = code;
                    out_pos   = 11;
                    sdo       = code[11];
                    rises     = 0;
                    cfg_bits  = 0;
                    cfg       = '0;
                    last_conv = cyc;
                    conv_idx++;
                end

                if (sck && !prev_sck) begin
                    rises++;
                    if (cfg_bits < 6) begin
                        cfg = {cfg[4:0], sdi};
                        cfg_bits++;
                    end else begin
                        chk("sdi_idle", sdi, 1'b0);
                    end
                end
                if (!sck && prev_sck) begin
                    out_pos--;
                    sdo = (out_pos >= 0) ? out_word[out_pos] : 1'b0;
                end

                prev_convst = convst;
                prev_sck    = sck;
                cyc++;
            end
        end
    end

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < budget);
        if (!valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_convst", convst, 1'b0);
        chk("rst_sck",    sck,    1'b0);
        chk("rst_sdi",    sdi,    1'b0);
        chk("rst_valid",  valid,  1'b0);
        chk("rst_value",  value,  24'h0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Abort in the middle of pass 5's serial transfer.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(conv_idx == 5 && sck) && n < 8 * c_FRAME);
        if (!(conv_idx == 5 && sck)) chk("pass5_timeout", 32'd0, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_convst", convst, 1'b0);
        chk("midrst_sck",    sck,    1'b0);
        chk("midrst_sdi",    sdi,    1'b0);
        chk("midrst_valid",  valid,  1'b0);
        chk("midrst_value",  value,  24'h0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        wait_valid((1 + 2 * c_AVG) * c_FRAME + 10);
        chk("fixed_pair", value, 24'hABC123);

        mode = 1;
        repeat (8) wait_valid(2 * c_AVG * c_FRAME + 10);
        mode = 2;
        repeat (6) wait_valid(2 * c_AVG * c_FRAME + 10);
        mode = 3;
        repeat (8) wait_valid(2 * c_AVG * c_FRAME + 10);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
